// File: rtl/e_branch_pipe.sv
// e_branch_pipe: two-stage pipelined branch/jump resolver.
//   S1 (on accept): compare r1 against r0, pick the direction from the take-mask,
//                   and compute the target and the link value.
//   S2 (output slot): compare against the front-end prediction, pick the redirect PC,
//                     and hold the result until the consumer takes it.
//   After a mispredict leaves the block, the FSM stops accepting work and drops
//   wrong-path ops until the backend flush arrives.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid_i / in_ready_o    input handshake
//   r0_i, r1_i, pc_i, imm_i    operands, branch PC, offset (sign-extended)
//   op_i                       [5] target base r1 (else pc), [4] signed compare,
//                              [2:0] take-mask {lt,eq,gt} of r1 relative to r0
//   tag_i                      ROB tag carried with the op
//   pred_taken_i, pred_tgt_i   front-end prediction
//   flush_i                    kills in-flight ops, releases BLOCK
//   out_valid_o / out_ready_i  output handshake
//   out_tag_o, out_taken_o, out_link_o, out_mispred_o, out_redir_o  result fields
//
// Optional build macro BRANCH_PERF_CNT_EN adds saturating counters
//   perf_br_o  (resolved ops handshaken) and perf_mis_o (of those, mispredicted).

module e_branch_pipe #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 28,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  r0_i,
  input  logic [XLEN-1:0]  r1_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [IMM_W-1:0] imm_i,
  input  logic [5:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_tgt_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_taken_o,
  output logic [XLEN-1:0]  out_link_o,
  output logic             out_mispred_o,
  output logic [XLEN-1:0]  out_redir_o
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_br_o,
  output logic [31:0]      perf_mis_o
`endif
);

  // state    | meaning
  // ST_RUN   | accepting ops, results flow normally
  // ST_BLOCK | mispredict emitted; no accepts, S1 ops dropped, waiting for flush_i
  typedef enum logic {ST_RUN, ST_BLOCK} state_t;

  state_t state_q, state_d;

  logic             s1_valid;
  logic             s1_taken;
  logic [XLEN-1:0]  s1_target;
  logic [XLEN-1:0]  s1_link;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_pred_taken;
  logic [XLEN-1:0]  s1_pred_tgt;

  logic out_free, s1_adv, accept, hs_out, mis_hs, kill;

  logic [XLEN:0]    cmp_a, cmp_b;
  logic             c_lt, c_eq, c_gt, c_taken;
  logic [XLEN-1:0]  imm_sext, tgt_base, c_target, c_link;
  logic             s2_mispred;
  logic [XLEN-1:0]  s2_redir;
  logic             unused_op3;

  assign unused_op3 = op_i[3];

  assign out_free = ~out_valid_o | out_ready_i;
  assign s1_adv   = ~s1_valid | out_free;
  assign hs_out   = out_valid_o & out_ready_i;
  assign mis_hs   = hs_out & out_mispred_o;
  assign accept   = in_valid_i & in_ready_o;

  // Signed compare by biasing: the extra MSB is the inverted sign bit for signed
  // ops (0 for unsigned), so a single unsigned 33-bit compare covers both.
  assign cmp_a = {~r1_i[XLEN-1] & op_i[4], r1_i};
  assign cmp_b = {~r0_i[XLEN-1] & op_i[4], r0_i};
  assign c_lt  = cmp_a < cmp_b;
  assign c_eq  = cmp_a == cmp_b;
  assign c_gt  = cmp_a > cmp_b;
  assign c_taken = |({c_lt, c_eq, c_gt} & op_i[2:0]);

  assign imm_sext = {{(XLEN-IMM_W){imm_i[IMM_W-1]}}, imm_i};
  assign tgt_base = op_i[5] ? r1_i : pc_i;
  assign c_target = imm_sext + tgt_base;
  assign c_link   = pc_i + XLEN'(4);

  assign s2_mispred = (s1_taken != s1_pred_taken) |
                      (s1_taken & (s1_target != s1_pred_tgt));
  assign s2_redir   = s1_taken ? s1_target : s1_link;

  // kill is also raised in the RUN cycle of a mispredict handshake, so the
  // wrong-path op sitting in S1 at that edge never reaches the output.
  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    kill       = 1'b0;
    case (state_q)
      ST_RUN: begin
        in_ready_o = s1_adv & ~flush_i & ~rst;
        kill       = mis_hs;
        if (mis_hs) state_d = ST_BLOCK;
      end
      ST_BLOCK: begin
        kill = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (flush_i) state_d = ST_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_taken      <= 1'b0;
      s1_target     <= '0;
      s1_link       <= '0;
      s1_tag        <= '0;
      s1_pred_taken <= 1'b0;
      s1_pred_tgt   <= '0;
    end else begin
      if (flush_i)     s1_valid <= 1'b0;
      else if (s1_adv) s1_valid <= accept;
      if (accept) begin
        s1_taken      <= c_taken;
        s1_target     <= c_target;
        s1_link       <= c_link;
        s1_tag        <= tag_i;
        s1_pred_taken <= pred_taken_i;
        s1_pred_tgt   <= pred_tgt_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o   <= 1'b0;
      out_tag_o     <= '0;
      out_taken_o   <= 1'b0;
      out_link_o    <= '0;
      out_mispred_o <= 1'b0;
      out_redir_o   <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (out_free) begin
      out_valid_o <= s1_valid & ~kill;
      if (s1_valid & ~kill) begin
        out_tag_o     <= s1_tag;
        out_taken_o   <= s1_taken;
        out_link_o    <= s1_link;
        out_mispred_o <= s2_mispred;
        out_redir_o   <= s2_redir;
      end
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_o  <= '0;
      perf_mis_o <= '0;
    end else begin
      if (hs_out && perf_br_o != 32'hFFFF_FFFF)  perf_br_o  <= perf_br_o + 32'd1;
      if (mis_hs && perf_mis_o != 32'hFFFF_FFFF) perf_mis_o <= perf_mis_o + 32'd1;
    end
  end
`endif

endmodule
